pipe_control_unit: RTL and testbench
====================================

PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, meaning register-specifier width.
REQ-002 SHALL have parameter OPCODE_W, default 6, meaning opcode width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have port id_valid, input, 1, meaning the ID-stage instruction is valid.
REQ-006 SHALL have port opcode, input, OPCODE_W, meaning the ID-stage opcode.
REQ-007 SHALL have ports id_rs and id_rt, input, REG_ADDR_W each, meaning the ID-stage source registers.
REQ-008 SHALL have port branch_taken, input, 1, meaning a branch resolved taken in MEM.
REQ-009 SHALL have ports pc_write and ifid_write, output, 1 each, meaning PC and IF/ID enables.
REQ-010 SHALL have port flush_ifid, output, 1, meaning clear the IF/ID register.
REQ-011 SHALL have port jump, output, 1, meaning the ID instruction is an unconditional jump.
REQ-012 SHALL have ports EX_control (4), M_control (4) and WB_control (2), all outputs, meaning registered per-stage control; M_control bit 0 is BOP.

Function
REQ-013 SHALL decode opcode to {EX,M,WB}:
- LW 100011: 0100/1000/10.
- SW 101011: 0100/0100/00.
- BEQ 000100: 0001/0011/00.
- BNE 000101: 0001/0010/00.
- R-type 000000: 1010/0000/11.
- ADDI/ANDI/SLTI/ORI/XORI (001000/001100/001010/001101/001110): 1110/0000/11.
- Other: all zero. Don't-care bits SHALL be driven 0.
REQ-014 SHALL hold three bundle registers: ID/EX {EX,M,WB,rt}, EX/MEM {M,WB}, MEM/WB {WB}.
REQ-015 SHALL drive EX_control from ID/EX, M_control from EX/MEM and WB_control from MEM/WB.
REQ-016 SHALL present an opcode sampled at edge n on EX_control after edge n+1, on M_control after n+2 and on WB_control after n+3.
REQ-017 SHALL load a zero bundle (bubble) into ID/EX when id_valid=0.
REQ-018 SHALL detect load-use (combinational): ID/EX M[3]=1 AND id_valid AND ID/EX rt!=0 AND (rt==id_rs OR rt==id_rt).
REQ-019 SHALL, on load-use, drive pc_write=0 and ifid_write=0 and load a bubble into ID/EX, while EX/MEM and MEM/WB advance normally.
REQ-020 SHALL drive pc_write=1 and ifid_write=1 when neither load-use nor flush applies.
REQ-021 SHALL, on branch_taken=1, drive flush_ifid=1 and load zero bundles into ID/EX and EX/MEM at the next edge; MEM/WB SHALL capture normally.
REQ-022 SHALL give branch_taken priority over load-use: stall is suppressed and pc_write=1 in that cycle.

Reset
REQ-023 SHALL, with reset=1 at an edge, clear all bundle registers, so EX_control=0, M_control=0 and WB_control=0 after that edge.
REQ-024 SHALL force pc_write=1, ifid_write=1, flush_ifid=0 and jump=0 while reset=1, overriding any operation in flight.

Configuration
REQ-025 SHALL, with CTRL_JUMP_EN defined, decode J 000010 to a zero bundle with jump=1 and flush_ifid=1 (combinational, gated by id_valid).
REQ-026 SHALL, without CTRL_JUMP_EN, tie jump to 0 and treat 000010 as the default opcode.

Structure
REQ-027 SHALL take opcode constants and bundle widths from shared package ctrl_pkg.
REQ-028 SHALL implement the decode of REQ-013 in combinational sub-module control_decode; pipeline registers and hazard logic live in the top module.

Verification
REQ-029 SHALL cover: R-type 000000 at edge 0 -> EX_control=1010 after edge 1, M_control=0000 after edge 2, WB_control=11 after edge 3.
REQ-030 SHALL cover: LW with rt=5, then ADD with id_rs=5 -> pc_write=ifid_write=0 for one cycle, EX_control=0000 bubble, then ADD proceeds.
REQ-031 SHALL cover: LW with rt=0, then consumer with id_rs=0 -> no stall.
REQ-032 SHALL cover: BEQ reaches MEM with branch_taken=1 and LW in ID/EX matching ID -> flush_ifid=1, pc_write=1, ID/EX and EX/MEM zero next cycle.
REQ-033 SHALL cover: reset asserted mid-stream with LW in EX/MEM -> all outputs zero after the edge and pc_write=1.
REQ-034 SHALL cover: with CTRL_JUMP_EN, opcode 000010 -> jump=1 and flush_ifid=1; without it, jump=0 and a zero bundle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared opcode constants and control-bundle layout for the pipeline control unit.
// Optional build macro CTRL_JUMP_EN enables decode of the J opcode.
package ctrl_pkg;

  localparam int OPC_W = 6;
  localparam int EX_W  = 4;
  localparam int M_W   = 4;
  localparam int WB_W  = 2;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPC_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;

  typedef struct packed {
    logic [EX_W-1:0] ex;
    logic [M_W-1:0]  m;   // m[3] = memory read (load), m[0] = BOP
    logic [WB_W-1:0] wb;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

  function automatic ctrl_bundle_t mk_bundle(input logic [EX_W-1:0] ex,
                                             input logic [M_W-1:0]  m,
                                             input logic [WB_W-1:0] wb);
    ctrl_bundle_t b;
    b.ex = ex;
    b.m  = m;
    b.wb = wb;
    return b;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder producing the {EX,M,WB} control bundle.
// With CTRL_JUMP_EN defined, J (000010) is flagged through is_jump_o.
module control_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output ctrl_bundle_t        bundle_o,
  output logic                is_jump_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    bundle_o  = BUBBLE;
    is_jump_o = 1'b0;
    case (opcode_i)
      OPCODE_W'(OP_LW):    bundle_o = mk_bundle(4'b0100, 4'b1000, 2'b10);
      OPCODE_W'(OP_SW):    bundle_o = mk_bundle(4'b0100, 4'b0100, 2'b00);
      OPCODE_W'(OP_BEQ):   bundle_o = mk_bundle(4'b0001, 4'b0011, 2'b00);
      OPCODE_W'(OP_BNE):   bundle_o = mk_bundle(4'b0001, 4'b0010, 2'b00);
      OPCODE_W'(OP_RTYPE): bundle_o = mk_bundle(4'b1010, 4'b0000, 2'b11);
      OPCODE_W'(OP_ADDI),
      OPCODE_W'(OP_ANDI),
      OPCODE_W'(OP_SLTI),
      OPCODE_W'(OP_ORI),
      OPCODE_W'(OP_XORI):  bundle_o = mk_bundle(4'b1110, 4'b0000, 2'b11);
`ifdef CTRL_JUMP_EN
      OPCODE_W'(OP_J):     is_jump_o = 1'b1;
`endif
      default:             bundle_o = BUBBLE;
    endcase
  end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipeline control: decode, ID/EX, EX/MEM, MEM/WB control registers, load-use stall
// and branch flush. Optional build macro CTRL_JUMP_EN adds unconditional-jump decode.
module pipe_control_unit
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int OPCODE_W   = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  branch_taken,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  flush_ifid,
  output logic                  jump,
  output logic [EX_W-1:0]       EX_control,
  output logic [M_W-1:0]        M_control,
  output logic [WB_W-1:0]       WB_control
);

  ctrl_bundle_t dec_bundle;
  logic         dec_jump;

  ctrl_bundle_t          idex_q, idex_d;
  logic [REG_ADDR_W-1:0] idex_rt_q, idex_rt_d;
  logic [M_W-1:0]        exmem_m_q, exmem_m_d;
  logic [WB_W-1:0]       exmem_wb_q, exmem_wb_d;
  logic [WB_W-1:0]       memwb_wb_q, memwb_wb_d;

  logic load_use;
  logic stall;
  logic advance_id;

  control_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode_i  (opcode),
    .bundle_o  (dec_bundle),
    .is_jump_o (dec_jump)
  );

  always_comb begin
    load_use = idex_q.m[3] && id_valid && (idex_rt_q != '0) &&
               ((idex_rt_q == id_rs) || (idex_rt_q == id_rt));
    // A taken branch squashes the consumer anyway, so it wins over the stall.
    stall      = load_use && !branch_taken;
    advance_id = id_valid && !stall && !branch_taken;

    pc_write   = reset || !stall;
    ifid_write = reset || !stall;
    jump       = dec_jump && id_valid && !reset;
    flush_ifid = !reset && (branch_taken || jump);

    idex_d     = advance_id ? dec_bundle : BUBBLE;
    idex_rt_d  = advance_id ? id_rt : '0;
    exmem_m_d  = branch_taken ? '0 : idex_q.m;
    exmem_wb_d = branch_taken ? '0 : idex_q.wb;
    memwb_wb_d = exmem_wb_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q     <= BUBBLE;
      idex_rt_q  <= '0;
      exmem_m_q  <= '0;
      exmem_wb_q <= '0;
      memwb_wb_q <= '0;
    end else begin
      idex_q     <= idex_d;
      idex_rt_q  <= idex_rt_d;
      exmem_m_q  <= exmem_m_d;
      exmem_wb_q <= exmem_wb_d;
      memwb_wb_q <= memwb_wb_d;
    end
  end

  assign EX_control = idex_q.ex;
  assign M_control  = exmem_m_q;
  assign WB_control = memwb_wb_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed self-checking bench for pipe_control_unit; jump checks follow CTRL_JUMP_EN.
module tb_pipe_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [5:0] opcode;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       branch_taken;
  logic       pc_write;
  logic       ifid_write;
  logic       flush_ifid;
  logic       jump;
  logic [3:0] EX_control;
  logic [3:0] M_control;
  logic [1:0] WB_control;

  int checks = 0;
  int errors = 0;

  pipe_control_unit #(.REG_ADDR_W(5), .OPCODE_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .opcode       (opcode),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .branch_taken (branch_taken),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .flush_ifid   (flush_ifid),
    .jump         (jump),
    .EX_control   (EX_control),
    .M_control    (M_control),
    .WB_control   (WB_control)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic bt);
    id_valid     = v;
    opcode       = op;
    id_rs        = rs;
    id_rt        = rt;
    branch_taken = bt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 6'b0, 5'd0, 5'd0, 1'b0);
    repeat (3) tick();
  endtask

  // Hand-written {EX,M,WB} table.
  function automatic logic [9:0] exp_bundle(input logic [5:0] op);
    case (op)
      6'b100011: return 10'b0100_1000_10;
      6'b101011: return 10'b0100_0100_00;
      6'b000100: return 10'b0001_0011_00;
      6'b000101: return 10'b0001_0010_00;
      6'b000000: return 10'b1010_0000_11;
      6'b001000, 6'b001100, 6'b001010, 6'b001101, 6'b001110: return 10'b1110_0000_11;
      default:   return 10'b0;
    endcase
  endfunction

  logic [5:0] stream [12];
  logic [9:0] e0, e1, e2;

  initial begin
    stream = '{6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000000, 6'b001000,
               6'b001100, 6'b001010, 6'b001101, 6'b001110, 6'b111111, 6'b000010};

    // Reset state
    reset = 1'b1;
    drive(1'b0, 6'b0, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    check("rst_ex", 32'(EX_control), 32'h0);
    check("rst_m", 32'(M_control), 32'h0);
    check("rst_wb", 32'(WB_control), 32'h0);
    check("rst_pcw", 32'(pc_write), 32'h1);
    check("rst_ifidw", 32'(ifid_write), 32'h1);
    check("rst_flush", 32'(flush_ifid), 32'h0);
    check("rst_jump", 32'(jump), 32'h0);
    reset = 1'b0;
    tick();

    // R-type latency through the three stages
    drive(1'b1, 6'b000000, 5'd1, 5'd2, 1'b0);
    tick();
    check("rtype_ex", 32'(EX_control), 32'hA);
    drive(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0);
    tick();
    check("rtype_m", 32'(M_control), 32'h0);
    check("invalid_bubble_ex", 32'(EX_control), 32'h0);
    tick();
    check("rtype_wb", 32'(WB_control), 32'h3);
    drain();

    // Back-to-back decode stream; register operands zero so no hazards
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, stream[i], 5'd0, 5'd0, 1'b0);
      tick();
      e0 = exp_bundle(stream[i]);
      check($sformatf("stream_ex_%0d", i), 32'(EX_control), 32'(e0[9:6]));
      if (i >= 1) begin
        e1 = exp_bundle(stream[i-1]);
        check($sformatf("stream_m_%0d", i), 32'(M_control), 32'(e1[5:2]));
      end
      if (i >= 2) begin
        e2 = exp_bundle(stream[i-2]);
        check($sformatf("stream_wb_%0d", i), 32'(WB_control), 32'(e2[1:0]));
      end
      check($sformatf("stream_pcw_%0d", i), 32'(pc_write), 32'h1);
    end
    drain();

    // Load-use on rs: one stall cycle, bubble, then consumer proceeds
    drive(1'b1, 6'b100011, 5'd3, 5'd5, 1'b0);
    tick();
    drive(1'b1, 6'b000000, 5'd5, 5'd6, 1'b0);
    #1;
    check("lu_pcw", 32'(pc_write), 32'h0);
    check("lu_ifidw", 32'(ifid_write), 32'h0);
    check("lu_flush", 32'(flush_ifid), 32'h0);
    tick();
    check("lu_bubble_ex", 32'(EX_control), 32'h0);
    check("lu_lw_m", 32'(M_control), 32'h8);
    check("lu_release_pcw", 32'(pc_write), 32'h1);
    tick();
    check("lu_add_ex", 32'(EX_control), 32'hA);
    check("lu_bubble_m", 32'(M_control), 32'h0);
    check("lu_lw_wb", 32'(WB_control), 32'h2);
    drain();

    // Load-use on rt
    drive(1'b1, 6'b100011, 5'd3, 5'd5, 1'b0);
    tick();
    drive(1'b1, 6'b101011, 5'd1, 5'd5, 1'b0);
    #1;
    check("lu_rt_pcw", 32'(pc_write), 32'h0);
    drain();

    // Load writing r0 never stalls
    drive(1'b1, 6'b100011, 5'd2, 5'd0, 1'b0);
    tick();
    drive(1'b1, 6'b000000, 5'd0, 5'd0, 1'b0);
    #1;
    check("lu_r0_pcw", 32'(pc_write), 32'h1);
    check("lu_r0_ifidw", 32'(ifid_write), 32'h1);
    tick();
    check("lu_r0_ex", 32'(EX_control), 32'hA);
    drain();

    // Matching registers but invalid ID instruction: no stall
    drive(1'b1, 6'b100011, 5'd2, 5'd4, 1'b0);
    tick();
    drive(1'b0, 6'b000000, 5'd4, 5'd4, 1'b0);
    #1;
    check("lu_invalid_pcw", 32'(pc_write), 32'h1);
    drain();

    // Taken branch in MEM overrides load-use and flushes ID/EX, EX/MEM
    drive(1'b1, 6'b000100, 5'd1, 5'd2, 1'b0);
    tick();
    drive(1'b1, 6'b100011, 5'd1, 5'd7, 1'b0);
    tick();
    check("br_beq_m", 32'(M_control), 32'h3);
    check("br_lw_ex", 32'(EX_control), 32'h4);
    drive(1'b1, 6'b000000, 5'd7, 5'd0, 1'b1);
    #1;
    check("br_flush", 32'(flush_ifid), 32'h1);
    check("br_pcw", 32'(pc_write), 32'h1);
    check("br_ifidw", 32'(ifid_write), 32'h1);
    tick();
    drive(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0);
    check("br_idex_zero", 32'(EX_control), 32'h0);
    check("br_exmem_zero", 32'(M_control), 32'h0);
    check("br_memwb_beq", 32'(WB_control), 32'h0);
    drain();

    // MEM/WB still captures normally during a flush
    drive(1'b1, 6'b000000, 5'd1, 5'd2, 1'b0);
    tick();
    drive(1'b1, 6'b100011, 5'd1, 5'd8, 1'b0);
    tick();
    drive(1'b1, 6'b000000, 5'd8, 5'd0, 1'b1);
    tick();
    drive(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0);
    check("br_memwb_capture", 32'(WB_control), 32'h3);
    check("br2_exmem_zero", 32'(M_control), 32'h0);
    check("br2_idex_zero", 32'(EX_control), 32'h0);
    drain();

    // Reset mid-stream with a load in EX/MEM and a stall pending
    drive(1'b1, 6'b100011, 5'd1, 5'd9, 1'b0);
    tick();
    drive(1'b1, 6'b100011, 5'd2, 5'd10, 1'b0);
    tick();
    check("mid_lw_m", 32'(M_control), 32'h8);
    drive(1'b1, 6'b000000, 5'd10, 5'd0, 1'b0);
    #1;
    check("mid_stall_pcw", 32'(pc_write), 32'h0);
    reset = 1'b1;
    branch_taken = 1'b1;
    #1;
    check("mid_rst_pcw", 32'(pc_write), 32'h1);
    check("mid_rst_ifidw", 32'(ifid_write), 32'h1);
    check("mid_rst_flush", 32'(flush_ifid), 32'h0);
    check("mid_rst_jump", 32'(jump), 32'h0);
    tick();
    check("mid_rst_ex", 32'(EX_control), 32'h0);
    check("mid_rst_m", 32'(M_control), 32'h0);
    check("mid_rst_wb", 32'(WB_control), 32'h0);
    reset = 1'b0;
    drain();

    // Jump opcode
    drive(1'b1, 6'b000010, 5'd0, 5'd0, 1'b0);
    #1;
`ifdef CTRL_JUMP_EN
    check("j_jump", 32'(jump), 32'h1);
    check("j_flush", 32'(flush_ifid), 32'h1);
`else
    check("j_jump", 32'(jump), 32'h0);
    check("j_flush", 32'(flush_ifid), 32'h0);
`endif
    check("j_pcw", 32'(pc_write), 32'h1);
    tick();
    drive(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0);
    #1;
    check("j_ex", 32'(EX_control), 32'h0);
    check("j_jump_invalid", 32'(jump), 32'h0);
    tick();
    check("j_m", 32'(M_control), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
